eprisc_interrupt_controller: RTL and testbench

- Memory-mapped interrupt controller directly upstream of the epRISC core.
- Collects pSources external interrupt lines plus one non-maskable source. Latches, masks and prioritises them, then drives the core's iMaskInt and iNonMaskInt inputs.
- Firmware services it over the core's 32-bit system bus: address, read/write strobe, and a split data path that the top level merges onto the tri-state bData.

---
 rtl/eprisc_intc_pkg.sv | 20 ++
 rtl/eprisc_intc_input.sv | 42 ++++
 rtl/eprisc_interrupt_controller.sv | 155 +++++++++++++++
 tb/tb_eprisc_interrupt_controller.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eprisc_intc_pkg.sv
// Shared constants for the epRISC interrupt controller: register offsets,
// NMI state encoding and register field positions.
package eprisc_intc_pkg;

  localparam logic [2:0] REG_PEND   = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_MODE   = 3'd2;
  localparam logic [2:0] REG_VEC    = 3'd3;
  localparam logic [2:0] REG_NMICTL = 3'd4;

  localparam logic [1:0] NMI_IDLE    = 2'd0;
  localparam logic [1:0] NMI_ACTIVE  = 2'd1;
  localparam logic [1:0] NMI_SERVICE = 2'd2;

  localparam int VEC_VALID_BIT    = 31;
  localparam int NMICTL_LATCH_BIT = 0;
  localparam int NMICTL_STATE_LSB = 1;
  localparam int NMICTL_ACK_BIT   = 0;

endpackage

// File: rtl/eprisc_intc_input.sv
// One interrupt source: optional 2-flop synchroniser (EPRISC_INTC_SYNC_EN),
// sample register and edge/level trigger output.
module eprisc_intc_input (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  output logic trig
);

  logic samp_in_s;
  logic q_r;
  logic q_prev_r;

`ifdef EPRISC_INTC_SYNC_EN
  logic [1:0] sync_r;

  // two-stage synchroniser for asynchronous source lines
  always_ff @(posedge clk) begin
    if (rst) sync_r <= 2'b00;
    else     sync_r <= {sync_r[0], src};
  end

  assign samp_in_s = sync_r[1];
`else
  assign samp_in_s = src;
`endif

  // sample register and its one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r      <= 1'b0;
      q_prev_r <= 1'b0;
    end else begin
      q_r      <= samp_in_s;
      q_prev_r <= q_r;
    end
  end

  assign trig = edge_mode ? (q_r & ~q_prev_r) : q_r;

endmodule

// File: rtl/eprisc_interrupt_controller.sv
// Memory-mapped interrupt controller feeding epRISC iMaskInt/iNonMaskInt.
// Source synchronisers are enabled with EPRISC_INTC_SYNC_EN.
module eprisc_interrupt_controller
  import eprisc_intc_pkg::*;
#(
  parameter int          pSources  = 8,
  parameter logic [31:0] pBaseAddr = 32'hFFFF_FF00,
  parameter int          pNmiPulse = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [31:0]         iAddr,
  input  logic [31:0]         iData,
  input  logic                iWrite,
  output logic [31:0]         oData,
  output logic                oDataEn,
  input  logic [pSources-1:0] iSrc,
  input  logic                iNmiSrc,
  output logic                oMaskInt,
  output logic                oNonMaskInt
);

  localparam logic [3:0] PULSE_LOAD = 4'(pNmiPulse);

  logic [pSources-1:0] pend_r;
  logic [pSources-1:0] mask_r;
  logic [pSources-1:0] mode_r;
  logic [pSources-1:0] trig_s;
  logic [pSources-1:0] w1c_s;
  logic [pSources-1:0] act_s;
  logic [4:0]          vec_idx_s;
  logic                mask_int_r;
  logic                nmi_trig_s;
  logic                nmi_latch_r;
  logic [1:0]          nmi_state_r;
  logic [3:0]          nmi_cnt_r;
  logic                sel_s;
  logic                wr_s;
  logic                ack_s;
  logic [2:0]          off_s;
  logic [31:0]         rdata_s;
  logic                unused_data_s;

  assign sel_s = (iAddr[31:3] == pBaseAddr[31:3]);
  assign off_s = iAddr[2:0];
  assign wr_s  = sel_s & iWrite;
  assign ack_s = wr_s & (off_s == REG_NMICTL) & iData[NMICTL_ACK_BIT];
  assign unused_data_s = ^iData;

  genvar gi;
  generate
    for (gi = 0; gi < pSources; gi++) begin : g_src
      eprisc_intc_input u_src (
        .clk       (iClk),
        .rst       (iRst),
        .src       (iSrc[gi]),
        .edge_mode (mode_r[gi]),
        .trig      (trig_s[gi])
      );
    end
  endgenerate

  eprisc_intc_input u_nmi (
    .clk       (iClk),
    .rst       (iRst),
    .src       (iNmiSrc),
    .edge_mode (1'b1),
    .trig      (nmi_trig_s)
  );

  // write-1-to-clear mask and active/priority vector
  always_comb begin
    w1c_s     = '0;
    act_s     = pend_r & mask_r;
    vec_idx_s = 5'd0;
    if (wr_s && (off_s == REG_PEND)) w1c_s = iData[pSources-1:0];
    else                             w1c_s = '0;
    for (int k = pSources - 1; k >= 0; k--) begin
      vec_idx_s = act_s[k] ? k[4:0] : vec_idx_s;
    end
  end

  // pending/mask/mode registers; level bits ignore W1C, and a new edge beats a clear
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pend_r     <= '0;
      mask_r     <= '0;
      mode_r     <= '1;
      mask_int_r <= 1'b0;
    end else begin
      pend_r     <= (pend_r & ~w1c_s & mode_r) | trig_s;
      mask_int_r <= |act_s;
      if (wr_s && (off_s == REG_MASK)) mask_r <= iData[pSources-1:0];
      if (wr_s && (off_s == REG_MODE)) mode_r <= iData[pSources-1:0];
    end
  end

  // NMI pulse sequencer; the latch keeps edges seen while busy for a later retrigger
  always_ff @(posedge iClk) begin
    if (iRst) begin
      nmi_state_r <= NMI_IDLE;
      nmi_latch_r <= 1'b0;
      nmi_cnt_r   <= 4'd0;
    end else begin
      case (nmi_state_r)
        NMI_IDLE: begin
          nmi_latch_r <= nmi_trig_s;
          if (nmi_latch_r) begin
            nmi_state_r <= NMI_ACTIVE;
            nmi_cnt_r   <= PULSE_LOAD;
          end
        end
        NMI_ACTIVE: begin
          nmi_latch_r <= nmi_latch_r | nmi_trig_s;
          nmi_cnt_r   <= nmi_cnt_r - 4'd1;
          if (nmi_cnt_r == 4'd1) nmi_state_r <= NMI_SERVICE;
        end
        NMI_SERVICE: begin
          nmi_latch_r <= nmi_latch_r | nmi_trig_s;
          if (ack_s) nmi_state_r <= NMI_IDLE;
        end
        default: begin
          nmi_state_r <= NMI_IDLE;
          nmi_latch_r <= 1'b0;
          nmi_cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // side-effect-free register read mux
  always_comb begin
    rdata_s = 32'd0;
    case (off_s)
      REG_PEND: rdata_s[pSources-1:0] = pend_r;
      REG_MASK: rdata_s[pSources-1:0] = mask_r;
      REG_MODE: rdata_s[pSources-1:0] = mode_r;
      REG_VEC: begin
        rdata_s[VEC_VALID_BIT] = |act_s;
        rdata_s[4:0]           = vec_idx_s;
      end
      REG_NMICTL: begin
        rdata_s[NMICTL_LATCH_BIT]       = nmi_latch_r;
        rdata_s[NMICTL_STATE_LSB +: 2]  = nmi_state_r;
      end
      default: rdata_s = 32'd0;
    endcase
  end

  assign oDataEn     = sel_s & ~iWrite;
  assign oData       = oDataEn ? rdata_s : 32'd0;
  assign oMaskInt    = mask_int_r;
  assign oNonMaskInt = (nmi_state_r == NMI_ACTIVE);

endmodule

// File: tb/tb_eprisc_interrupt_controller.sv
// Self-checking bench for eprisc_interrupt_controller: directed scenarios plus
// randomized traffic against a cycle-level behavioural model of the register rules.
module tb_eprisc_interrupt_controller;

  localparam int          NSRC  = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam int          PULSE = 4;
`ifdef EPRISC_INTC_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int HL = 3 + SYNC;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            wr;
  logic [31:0]     rdata;
  logic            den;
  logic [NSRC-1:0] src;
  logic            nmi;
  logic            mint;
  logic            nmint;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [NSRC-1:0] raw_h [0:HL-1];
  logic            nmi_h [0:HL-1];
  logic [NSRC-1:0] m_pend, m_mask, m_mode;
  logic            m_mint, m_latch;
  int              m_st, m_cnt;

  always #5 clk = ~clk;

  eprisc_interrupt_controller #(
    .pSources (NSRC),
    .pBaseAddr(BASE),
    .pNmiPulse(PULSE)
  ) dut (
    .iClk       (clk),
    .iRst       (rst),
    .iAddr      (addr),
    .iData      (wdata),
    .iWrite     (wr),
    .oData      (rdata),
    .oDataEn    (den),
    .iSrc       (src),
    .iNmiSrc    (nmi),
    .oMaskInt   (mint),
    .oNonMaskInt(nmint)
  );

  // advance one clock, updating the model from the inputs seen at that edge; returns at negedge
  task automatic tick();
    logic [NSRC-1:0] s1, s2, edg, w1c;
    logic ne, wsel, ack;
    @(posedge clk);
    if (rst) begin
      m_pend = '0; m_mask = '0; m_mode = '1; m_mint = 1'b0;
      m_st = 0; m_cnt = 0; m_latch = 1'b0;
      for (int i = 0; i < HL; i++) begin raw_h[i] = '0; nmi_h[i] = 1'b0; end
    end else begin
      for (int i = HL - 1; i > 0; i--) begin raw_h[i] = raw_h[i-1]; nmi_h[i] = nmi_h[i-1]; end
      raw_h[0] = src;
      nmi_h[0] = nmi;
      s1   = raw_h[1+SYNC];
      s2   = raw_h[2+SYNC];
      edg  = s1 & ~s2;
      ne   = nmi_h[1+SYNC] & ~nmi_h[2+SYNC];
      wsel = wr && (addr[31:3] == BASE[31:3]);
      w1c  = (wsel && addr[2:0] == 3'd0) ? wdata[NSRC-1:0] : '0;
      ack  = wsel && (addr[2:0] == 3'd4) && wdata[0];
      m_mint = |(m_pend & m_mask);
      for (int i = 0; i < NSRC; i++) begin
        if (m_mode[i]) m_pend[i] = (m_pend[i] && !w1c[i]) || edg[i];
        else           m_pend[i] = s1[i];
      end
      if (wsel && addr[2:0] == 3'd1) m_mask = wdata[NSRC-1:0];
      if (wsel && addr[2:0] == 3'd2) m_mode = wdata[NSRC-1:0];
      case (m_st)
        0: begin
          if (m_latch) begin m_st = 1; m_cnt = PULSE; end
          m_latch = ne;
        end
        1: begin
          m_latch = m_latch | ne;
          m_cnt   = m_cnt - 1;
          if (m_cnt == 0) m_st = 2;
        end
        default: begin
          m_latch = m_latch | ne;
          if (ack) m_st = 0;
        end
      endcase
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0]     r;
    logic [NSRC-1:0] act;
    r   = 32'd0;
    act = m_pend & m_mask;
    if (a[31:3] == BASE[31:3]) begin
      case (a[2:0])
        3'd0: r[NSRC-1:0] = m_pend;
        3'd1: r[NSRC-1:0] = m_mask;
        3'd2: r[NSRC-1:0] = m_mode;
        3'd3: if (act != '0) begin
          r[31] = 1'b1;
          for (int i = NSRC - 1; i >= 0; i--) if (act[i]) r[4:0] = i[4:0];
        end
        3'd4: r[2:0] = {m_st[1:0], m_latch};
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  task automatic rd(input logic [2:0] off, output logic [31:0] d);
    addr = BASE | {29'd0, off};
    wr   = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic wr_reg(input logic [2:0] off, input logic [31:0] d);
    addr  = BASE | {29'd0, off};
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; src = '0; nmi = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    tick(); tick();
    checks++; if (mint !== 1'b0) begin errors++; $display("FAIL reset_mint got %b exp 0", mint); end
    checks++; if (nmint !== 1'b0) begin errors++; $display("FAIL reset_nmi got %b exp 0", nmint); end
    checks++; if (den !== 1'b0 || rdata !== 32'd0) begin errors++; $display("FAIL reset_bus got en=%b data=%h exp 0/0", den, rdata); end
    rst = 1'b0;
    rd(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_pend got %h exp 00000000", d); end
    rd(3'd2, d);
    checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL reset_mode got %h exp 000000ff", d); end
    rd(3'd4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_nmictl got %h exp 00000000", d); end
  endtask

  task automatic test_edge_basic();
    logic [31:0] d;
    wr_reg(3'd1, 32'h1);
    src = 8'h01; tick(); src = '0;
    repeat (SYNC) tick();
    rd(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL edge_pend_early got %h exp 00000000", d); end
    tick();
    rd(3'd0, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL edge_pend got %h exp 00000001", d); end
    checks++; if (mint !== 1'b0) begin errors++; $display("FAIL edge_mint_early got %b exp 0", mint); end
    tick();
    checks++; if (mint !== 1'b1) begin errors++; $display("FAIL edge_mint got %b exp 1", mint); end
    rd(3'd3, d);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL edge_vec got %h exp 80000000", d); end
    wr_reg(3'd0, 32'h1);
    checks++; if (mint !== 1'b1) begin errors++; $display("FAIL w1c_mint_hold got %b exp 1", mint); end
    tick();
    checks++; if (mint !== 1'b0) begin errors++; $display("FAIL w1c_mint_drop got %b exp 0", mint); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    wr_reg(3'd1, 32'hFF);
    src = 8'h24; tick(); src = '0;
    repeat (SYNC) tick();
    tick();
    rd(3'd3, d);
    checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL prio_vec got %h exp 80000002", d); end
    wr_reg(3'd0, 32'h4);
    rd(3'd3, d);
    checks++; if (d !== 32'h8000_0005) begin errors++; $display("FAIL prio_vec_next got %h exp 80000005", d); end
    wr_reg(3'd0, 32'hFF);
    rd(3'd3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL prio_vec_none got %h exp 00000000", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    src = 8'h08; tick(); src = '0;
    repeat (SYNC) tick();
    tick();
    rd(3'd0, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL coll_setup got %h exp 00000008", d); end
    src = 8'h08; tick(); src = '0;
    repeat (SYNC) tick();
    wr_reg(3'd0, 32'h8);
    rd(3'd0, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL coll_set_wins got %h exp 00000008", d); end
    wr_reg(3'd0, 32'h8);
    rd(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL coll_clear got %h exp 00000000", d); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    wr_reg(3'd2, 32'hFE);
    wr_reg(3'd1, 32'h01);
    src = 8'h01;
    repeat (3 + SYNC) tick();
    wr_reg(3'd0, 32'h1);
    rd(3'd0, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL level_w1c_ignored got %h exp 00000001", d); end
    checks++; if (mint !== 1'b1) begin errors++; $display("FAIL level_mint got %b exp 1", mint); end
    src = '0; tick();
    repeat (SYNC) tick();
    tick();
    rd(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL level_drop got %h exp 00000000", d); end
    checks++; if (mint !== 1'b1) begin errors++; $display("FAIL level_mint_lag got %b exp 1", mint); end
    tick();
    checks++; if (mint !== 1'b0) begin errors++; $display("FAIL level_mint_drop got %b exp 0", mint); end
    wr_reg(3'd2, 32'hFF);
    wr_reg(3'd1, 32'h00);
  endtask

  task automatic test_nmi();
    logic [31:0] d;
    int n;
    nmi = 1'b1; tick(); nmi = 1'b0;
    repeat (SYNC) tick();
    tick();
    rd(3'd4, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL nmi_latch got %h exp 00000001", d); end
    tick();
    checks++; if (nmint !== 1'b1) begin errors++; $display("FAIL nmi_start got %b exp 1", nmint); end
    n = 1;
    repeat (10) begin tick(); if (nmint) n++; end
    checks++; if (n != PULSE) begin errors++; $display("FAIL nmi_width got %0d exp %0d", n, PULSE); end
    rd(3'd4, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL nmi_service got %h exp 00000004", d); end
    nmi = 1'b1; tick(); nmi = 1'b0;
    repeat (SYNC) tick();
    tick();
    rd(3'd4, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL nmi_held got %h exp 00000005", d); end
    wr_reg(3'd4, 32'h1);
    rd(3'd4, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL nmi_ack got %h exp 00000001", d); end
    tick();
    n = nmint ? 1 : 0;
    wr_reg(3'd4, 32'h1);
    if (nmint) n++;
    repeat (10) begin tick(); if (nmint) n++; end
    checks++; if (n != PULSE) begin errors++; $display("FAIL nmi_retrigger_width got %0d exp %0d", n, PULSE); end
    wr_reg(3'd4, 32'h1);
    rd(3'd4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL nmi_idle got %h exp 00000000", d); end
  endtask

  task automatic test_reset_mid_nmi();
    logic [31:0] d;
    int budget;
    wr_reg(3'd1, 32'hFF);
    src = 8'h10; tick(); src = '0;
    nmi = 1'b1; tick(); nmi = 1'b0;
    budget = 0;
    while (!nmint && budget < 12) begin tick(); budget++; end
    checks++; if (nmint !== 1'b1) begin errors++; $display("FAIL rst_nmi_wait got %b exp 1 within 12 cycles", nmint); end
    rst = 1'b1; tick();
    checks++; if (nmint !== 1'b0) begin errors++; $display("FAIL rst_nmi_drop got %b exp 0", nmint); end
    rd(3'd4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_nmictl got %h exp 00000000", d); end
    rd(3'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_pend_lost got %h exp 00000000", d); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] d, a, e;
    int r;
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++; if (mint !== m_mint) begin errors++; $display("FAIL rnd_mint cyc %0d got %b exp %b", cyc, mint, m_mint); end
      checks++; if (nmint !== (m_st == 1)) begin errors++; $display("FAIL rnd_nmi cyc %0d got %b exp %b", cyc, nmint, (m_st == 1)); end
      a = BASE | 32'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = a ^ 32'h0000_0100;
      addr = a; wr = 1'b0; #1;
      e = exp_read(a);
      checks++; if (rdata !== e || den !== (a[31:3] == BASE[31:3])) begin
        errors++; $display("FAIL rnd_read cyc %0d addr %h got %h/%b exp %h/%b", cyc, a, rdata, den, e, (a[31:3] == BASE[31:3]));
      end
      src = NSRC'($urandom);
      nmi = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 9);
      if (r < 3) begin
        addr  = BASE | 32'($urandom_range(0, 7));
        wdata = $urandom;
        wr    = 1'b1;
      end
      tick();
      wr  = 1'b0;
      rst = 1'b0;
    end
    d = exp_read(BASE);
    rd(3'd0, a);
    checks++; if (a !== d) begin errors++; $display("FAIL rnd_final_pend got %h exp %h", a, d); end
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_priority();
    test_collision();
    test_level();
    test_nmi();
    test_reset_mid_nmi();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
